// File: rtl/dm.sv
// Byte-addressable data memory with sized/extended loads and a store counter.
// Optional store trace enabled by defining DM_WRITE_LOG_EN.
module dm #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_op,
    input  logic [2:0]  load_op,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        addr_err,
    output logic [31:0] wr_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;
    localparam logic [1:0] ST_SW = 2'b11;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LW  = 3'b101;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          addr_err_q, addr_err_d;
    logic [31:0]   wr_count_q;

    logic [AW-1:0] idx;
    logic          st_en, st_mis, st_commit;
    logic          ld_en, ld_mis;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic [31:0]   view;
    logic [7:0]    sel_b;
    logic [15:0]   sel_h;
    logic          unused_bits;

    // Upper address bits alias onto the low 4 KiB window.
    assign idx         = addr[AW+1:2];
    assign old_word    = mem_q[idx];
    assign unused_bits = ^{pc, addr[31:AW+2]};

    always_comb begin
        st_en  = 1'b0;
        st_mis = 1'b0;
        be     = 4'b0000;
        wlanes = wdata;
        unique case (store_op)
            ST_SB: begin
                st_en  = 1'b1;
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            ST_SH: begin
                st_en  = 1'b1;
                st_mis = addr[0];
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            ST_SW: begin
                st_en  = 1'b1;
                st_mis = |addr[1:0];
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: begin
                st_en  = 1'b0;
                st_mis = 1'b0;
            end
        endcase
    end

    assign st_commit = st_en & ~st_mis;

    always_comb begin
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wlanes[8*b +: 8];
            end
        end
    end

    // Write-first: a same-cycle load observes the merged word.
    assign view  = st_commit ? merged : old_word;
    assign sel_b = view[8*addr[1:0] +: 8];
    assign sel_h = addr[1] ? view[31:16] : view[15:0];

    always_comb begin
        ld_en   = 1'b0;
        ld_mis  = 1'b0;
        rdata_d = 32'h0;
        unique case (load_op)
            LD_LB: begin
                ld_en   = 1'b1;
                rdata_d = {{24{sel_b[7]}}, sel_b};
            end
            LD_LBU: begin
                ld_en   = 1'b1;
                rdata_d = {24'h0, sel_b};
            end
            LD_LH: begin
                ld_en   = 1'b1;
                ld_mis  = addr[0];
                rdata_d = {{16{sel_h[15]}}, sel_h};
            end
            LD_LHU: begin
                ld_en   = 1'b1;
                ld_mis  = addr[0];
                rdata_d = {16'h0, sel_h};
            end
            LD_LW: begin
                ld_en   = 1'b1;
                ld_mis  = |addr[1:0];
                rdata_d = view;
            end
            default: begin
                ld_en   = 1'b0;
                rdata_d = 32'h0;
            end
        endcase
        if (ld_mis) begin
            rdata_d = 32'h0;
        end
    end

    assign rvalid_d   = ld_en;
    assign addr_err_d = (st_en & st_mis) | (ld_en & ld_mis);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (st_commit) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            wr_count_q <= 32'h0;
        end else begin
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            if (ld_en) begin
                rdata_q <= rdata_d;
            end
            if (st_commit) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (reset && st_commit) begin
            $display("@%08h: *%08h <= %08h", pc,
                     {20'h0, addr[11:2], 2'b00}, merged);
        end
    end
`else
`endif

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign addr_err = addr_err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dm.sv
// Directed vector bench for dm: one table row per clock cycle,
// plus a hand sequence for reset arriving with a load in flight.
module tb_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  store_op;
    logic [2:0]  load_op;
    logic [31:0] rdata;
    logic        rvalid;
    logic        addr_err;
    logic [31:0] wr_count;

    int errors = 0;
    int checks = 0;

    dm dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .addr     (addr),
        .wdata    (wdata),
        .store_op (store_op),
        .load_op  (load_op),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .addr_err (addr_err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t v [$];

    function automatic vec_t mk(string n, logic r, logic [1:0] s,
                                logic [2:0] l, logic [31:0] a,
                                logic [31:0] w, logic rv,
                                logic [31:0] rd, logic er,
                                logic [31:0] c);
        vec_t t;
        t.name = n; t.rst_n = r; t.st = s; t.ld = l; t.a = a;
        t.wd = w; t.e_rv = rv; t.e_rd = rd; t.e_err = er; t.e_cnt = c;
        return t;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", n, act, exp);
        end
    endtask

    task automatic step(vec_t t);
        reset    = t.rst_n;
        store_op = t.st;
        load_op  = t.ld;
        addr     = t.a;
        wdata    = t.wd;
        pc       = pc + 32'd4;
        @(posedge clk);
        #1;
        chk({t.name, ".rvalid"},   {31'h0, rvalid},   {31'h0, t.e_rv});
        chk({t.name, ".rdata"},    rdata,             t.e_rd);
        chk({t.name, ".addr_err"}, {31'h0, addr_err}, {31'h0, t.e_err});
        chk({t.name, ".wr_count"}, wr_count,          t.e_cnt);
    endtask

    initial begin
        reset = 1'b0; pc = 32'h0; addr = 32'h0; wdata = 32'h0;
        store_op = 2'b00; load_op = 3'b000;

        //        name        rst st     ld      addr      wdata         rv rdata        err cnt
        v.push_back(mk("rst0",  0, 2'd0, 3'd0, 32'h0,    32'h0,         0, 32'h0,        0, 0));
        v.push_back(mk("rstacc",0, 2'd3, 3'd5, 32'h10,   32'hDEADBEEF,  0, 32'h0,        0, 0));
        v.push_back(mk("lw0",   1, 2'd0, 3'd5, 32'h0,    32'h0,         1, 32'h0,        0, 0));
        v.push_back(mk("sw10",  1, 2'd3, 3'd0, 32'h10,   32'h12345678,  0, 32'h0,        0, 1));
        v.push_back(mk("sb11",  1, 2'd1, 3'd0, 32'h11,   32'h000000AB,  0, 32'h0,        0, 2));
        v.push_back(mk("lw10",  1, 2'd0, 3'd5, 32'h10,   32'h0,         1, 32'h1234AB78, 0, 2));
        v.push_back(mk("idle",  1, 2'd0, 3'd0, 32'h0,    32'h0,         0, 32'h1234AB78, 0, 2));
        v.push_back(mk("sw20",  1, 2'd3, 3'd0, 32'h20,   32'h000080FF,  0, 32'h1234AB78, 0, 3));
        v.push_back(mk("lb20",  1, 2'd0, 3'd1, 32'h20,   32'h0,         1, 32'hFFFFFFFF, 0, 3));
        v.push_back(mk("lbu20", 1, 2'd0, 3'd2, 32'h20,   32'h0,         1, 32'h000000FF, 0, 3));
        v.push_back(mk("lh20",  1, 2'd0, 3'd3, 32'h20,   32'h0,         1, 32'hFFFF80FF, 0, 3));
        v.push_back(mk("lhu20", 1, 2'd0, 3'd4, 32'h20,   32'h0,         1, 32'h000080FF, 0, 3));
        v.push_back(mk("lb21",  1, 2'd0, 3'd1, 32'h21,   32'h0,         1, 32'hFFFFFF80, 0, 3));
        v.push_back(mk("shmis", 1, 2'd2, 3'd0, 32'h21,   32'h00005555,  0, 32'hFFFFFF80, 1, 3));
        v.push_back(mk("lwmis", 1, 2'd0, 3'd5, 32'h22,   32'h0,         1, 32'h0,        1, 3));
        v.push_back(mk("errend",1, 2'd0, 3'd0, 32'h0,    32'h0,         0, 32'h0,        0, 3));
        v.push_back(mk("lw20u", 1, 2'd0, 3'd5, 32'h20,   32'h0,         1, 32'h000080FF, 0, 3));
        v.push_back(mk("swmis", 1, 2'd3, 3'd0, 32'h12,   32'h11111111,  0, 32'h000080FF, 1, 3));
        v.push_back(mk("swlwal",1, 2'd3, 3'd5, 32'h1004, 32'hCAFEF00D,  1, 32'hCAFEF00D, 0, 4));
        v.push_back(mk("lw4",   1, 2'd0, 3'd5, 32'h4,    32'h0,         1, 32'hCAFEF00D, 0, 4));
        v.push_back(mk("sh22",  1, 2'd2, 3'd0, 32'h22,   32'h0000BEEF,  0, 32'hCAFEF00D, 0, 5));
        v.push_back(mk("lhu22", 1, 2'd0, 3'd4, 32'h22,   32'h0,         1, 32'h0000BEEF, 0, 5));
        v.push_back(mk("sblw20",1, 2'd1, 3'd5, 32'h20,   32'h00000011,  1, 32'hBEEF8011, 0, 6));
        v.push_back(mk("ldop6", 1, 2'd0, 3'd6, 32'h20,   32'h0,         0, 32'hBEEF8011, 0, 6));
        v.push_back(mk("lh22",  1, 2'd0, 3'd3, 32'h22,   32'h0,         1, 32'hFFFFBEEF, 0, 6));
        v.push_back(mk("lb13",  1, 2'd0, 3'd1, 32'h13,   32'h0,         1, 32'h00000012, 0, 6));

        @(negedge clk);
        for (int i = 0; i < v.size(); i++) begin
            step(v[i]);
        end

        // Reset arriving with a load in flight, then memory is cleared.
        step(mk("fl.lw",  1, 2'd0, 3'd5, 32'h10, 32'h0, 1, 32'h1234AB78, 0, 6));
        step(mk("fl.rst", 0, 2'd0, 3'd5, 32'h10, 32'h0, 0, 32'h0,        0, 0));
        step(mk("fl.idle",1, 2'd0, 3'd0, 32'h0,  32'h0, 0, 32'h0,        0, 0));
        step(mk("fl.sb",  1, 2'd1, 3'd0, 32'h3,  32'h000000A5, 0, 32'h0, 0, 1));
        step(mk("fl.lw10",1, 2'd0, 3'd5, 32'h10, 32'h0, 1, 32'h0,        0, 1));
        step(mk("fl.lw0", 1, 2'd0, 3'd5, 32'h0,  32'h0, 1, 32'hA5000000, 0, 1));
        step(mk("fl.lb3", 1, 2'd0, 3'd1, 32'h3,  32'h0, 1, 32'hFFFFFFA5, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm.md
DM -- requirements
Module: dm

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words; the word index is addr[11:2].
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset is synchronous and active-low.
REQ-004 Port: pc  input  32  PC of the instruction issuing the access; used only for the write log.
REQ-005 Port: addr  input  32  byte address of the access.
REQ-006 Port: wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 Port: store_op  input  2  operation code: 00 none, 01 sb, 10 sh, 11 sw.
REQ-008 Port: load_op  input  3  operation code: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; 110 and 111 are treated as none.
REQ-009 Port: rdata  output  32  extended load result, registered.
REQ-010 Port: rvalid  output  1  rdata holds the result of the previous cycle's load.
REQ-011 Port: addr_err  output  1  the previous cycle's access was misaligned.
REQ-012 Port: wr_count  output  32  number of stores committed since reset.

Function
REQ-013 Store: on a clk edge with store_op!=00, aligned address and reset high, dm SHALL write only the addressed lanes: sb lane addr[1:0], sh lanes {addr[1],0}/{addr[1],1}, sw all lanes; other lanes are unchanged.
REQ-014 Alignment: sh requires addr[0]=0 and lw/sw require addr[1:0]=00; sb/lb/lbu are always aligned.
REQ-015 Misaligned store: dm SHALL NOT change memory or wr_count, and SHALL set addr_err=1 for the next cycle.
REQ-016 Misaligned load: dm SHALL set rdata=0, rvalid=1 and addr_err=1 for the next cycle.
REQ-017 Load latency: exactly 1 cycle; rdata/rvalid are registered at the edge where load_op is sampled, and rvalid=0 in the following cycle if load_op=none.
REQ-018 Load extension: lb/lh sign-extend from bit 7/15 of the selected lane; lbu/lhu zero-extend; lw returns the full word.
REQ-019 Simultaneous store and load in one cycle: load_op and store_op non-zero together occur only for the same addr.
REQ-020 Same-cycle store and load SHALL be write-first: rdata reflects the merged post-store word.
REQ-021 rdata SHALL hold its value when rvalid=0 (no toggling on idle cycles).
REQ-022 Address bits [31:12] are ignored, so addresses wrap modulo 4 KiB (0x1000 aliases 0x0000).
REQ-023 wr_count increments by 1 per committed store and wraps from 0xFFFFFFFF to 0.
REQ-024 addr_err SHALL be a one-cycle pulse per misaligned access; it does not latch.

Reset
REQ-025 While reset=0 at a clk edge, all DEPTH words SHALL be cleared to 0, and rdata=0, rvalid=0, addr_err=0, wr_count=0.
REQ-026 Any access presented in a reset cycle SHALL be discarded, with no write, no load response and no count.
REQ-027 Reset asserted mid-sequence SHALL discard a load in flight: rvalid=0 on the cycle after reset.
REQ-028 Initial (power-on) memory content SHALL equal the post-reset content.

Configuration
REQ-029 Macro DM_WRITE_LOG_EN defined: each committed store SHALL print one line "@<pc 8 hex>: *<word-aligned addr 8 hex> <= <full merged word 8 hex>" at the commit edge.
REQ-030 Macro DM_WRITE_LOG_EN undefined: no simulation output is produced, and ports and behaviour are otherwise identical.

Verification
REQ-031 Reset held low for 2 cycles, then lw at 0x0 -> next cycle rdata=0x00000000, rvalid=1, wr_count=0.
REQ-032 sw 0x12345678 at 0x10, then sb 0xAB at 0x11, then lw 0x10 -> rdata=0x1234AB78, wr_count=2; with DM_WRITE_LOG_EN the second log line ends "*00000010 <= 1234ab78".
REQ-033 Word 0x000080FF at 0x20: lb 0x20 -> 0xFFFFFFFF; lbu 0x20 -> 0x000000FF; lh 0x20 -> 0xFFFF80FF; lhu 0x20 -> 0x000080FF.
REQ-034 sh at 0x21 and lw at 0x22 -> addr_err pulses 1 for one cycle each, memory unchanged, load rdata=0, wr_count unchanged.
REQ-035 sw 0xCAFEF00D and lw at 0x1004 in the same cycle -> next cycle rdata=0xCAFEF00D; lw 0x4 -> 0xCAFEF00D (alias).
REQ-036 lw issued in a cycle followed by reset=0 -> rvalid=0 in the cycle after reset.
